// File: rtl/seven_segment_scan_if.sv
// Display driver bundle: glyph/attribute inputs from control logic and
// registered segment/anode outputs toward the board pins.
interface seven_segment_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] nums;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink;
    logic [6:0]          display;
    logic                dot;
    logic [DIGITS-1:0]   digit;
    logic                frame_done;

    modport master (
        output nums, dp, blank, blink,
        input  display, dot, digit, frame_done
    );

    modport slave (
        input  nums, dp, blank, blink,
        output display, dot, digit, frame_done
    );
endinterface

// File: rtl/seven_segment_scan.sv
// Multiplexed common-anode N-digit 7-segment driver with frame-synchronous
// shadow registers, per-digit dp/blank/blink and a frame_done pulse.
module seven_segment_scan #(
    parameter int DIGITS     = 4,
    parameter int DIV_BITS   = 16,
    parameter int BLINK_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_segment_scan_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [DIV_BITS-1:0]   div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BLINK_BITS-1:0] blk_q, blk_d;
    logic [4*DIGITS-1:0]   gly_q, gly_d;
    logic [DIGITS-1:0]     sdp_q, sdp_d;
    logic [DIGITS-1:0]     sbl_q, sbl_d;
    logic [DIGITS-1:0]     sbk_q, sbk_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dot_q, dot_d;
    logic [DIGITS-1:0]     dig_q, dig_d;
    logic                  fd_q, fd_d;

    logic       tick;
    logic       frame_start;
    logic [3:0] glyph;
    logic       dark;

    function automatic logic [6:0] decode(input logic [3:0] g);
        logic [6:0] s;
        unique case (g)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state: divider, scan index, frame reload with bypass, and outputs
    always_comb begin
        div_d       = div_q + DIV_BITS'(1);
        tick        = &div_q;
        frame_start = tick && (idx_q == LAST);
        idx_d       = idx_q;
        blk_d       = blk_q;
        gly_d       = gly_q;
        sdp_d       = sdp_q;
        sbl_d       = sbl_q;
        sbk_d       = sbk_q;
        seg_d       = seg_q;
        dot_d       = dot_q;
        dig_d       = dig_q;
        fd_d        = 1'b0;
        glyph       = 4'hF;
        dark        = 1'b1;
        if (tick) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
            // New frame: latch inputs; digit 0 decodes from them directly
            if (frame_start) begin
                gly_d = bus.nums;
                sdp_d = bus.dp;
                sbl_d = bus.blank;
                sbk_d = bus.blink;
                blk_d = blk_q + BLINK_BITS'(1);
                fd_d  = 1'b1;
            end
            glyph = gly_d[{idx_d, 2'b00} +: 4];
            dark  = sbl_d[idx_d] || (sbk_d[idx_d] && blk_d[BLINK_BITS-1]);
            dig_d = ~(DIGITS'(1) << idx_d);
            seg_d = dark ? 7'b1111111 : decode(glyph);
            dot_d = dark ? 1'b1 : ~sdp_d[idx_d];
        end
    end

    // State and output registers, async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= LAST;
            blk_q <= '0;
            gly_q <= '1;
            sdp_q <= '0;
            sbl_q <= '0;
            sbk_q <= '0;
            seg_q <= 7'b1111111;
            dot_q <= 1'b1;
            dig_q <= '1;
            fd_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            blk_q <= blk_d;
            gly_q <= gly_d;
            sdp_q <= sdp_d;
            sbl_q <= sbl_d;
            sbk_q <= sbk_d;
            seg_q <= seg_d;
            dot_q <= dot_d;
            dig_q <= dig_d;
            fd_q  <= fd_d;
        end
    end

    assign bus.display    = seg_q;
    assign bus.dot        = dot_q;
    assign bus.digit      = dig_q;
    assign bus.frame_done = fd_q;
endmodule
